// File: rtl/alu_mul_sequencer_pkg.sv
// rtl/alu_mul_sequencer_pkg.sv - ALU select codes and sequencer state encoding
package alu_mul_sequencer_pkg;

  localparam logic [2:0] ALU_COMP = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_DEC  = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_INC  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_port_mux.sv
// rtl/alu_port_mux.sv - ALU input mux: EX-stage passthrough or sequencer-owned add
module alu_port_mux #(
  parameter int WIDTH = 32
) (
  input  logic             owned,
  input  logic [2:0]       own_sel,
  input  logic [WIDTH-1:0] own_inp1,
  input  logic [WIDTH-1:0] own_addend,
  input  logic             own_gate,
  input  logic [WIDTH-1:0] ex_inp1,
  input  logic [WIDTH-1:0] ex_inp2,
  input  logic [2:0]       ex_sel,
  output logic [WIDTH-1:0] alu_inp1,
  output logic [WIDTH-1:0] alu_inp2,
  output logic [2:0]       alu_sel
);

  // The multiplicand is only added when the current multiplier bit is set.
  always_comb begin
    alu_inp1 = ex_inp1;
    alu_inp2 = ex_inp2;
    alu_sel  = ex_sel;
    if (owned) begin
      alu_inp1 = own_inp1;
      alu_inp2 = own_gate ? own_addend : '0;
      alu_sel  = own_sel;
    end
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - borrows the shared ALU to run unsigned shift-add multiply
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter int         CNT_W   = 5,
  parameter logic [2:0] SEL_ADD = ALU_ADD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mul_a,
  input  logic [WIDTH-1:0]   mul_b,
  input  logic [WIDTH-1:0]   ex_inp1,
  input  logic [WIDTH-1:0]   ex_inp2,
  input  logic [2:0]         ex_sel,
  input  logic [WIDTH-1:0]   alu_outp,
  output logic [WIDTH-1:0]   alu_inp1,
  output logic [WIDTH-1:0]   alu_inp2,
  output logic [2:0]         alu_sel,
  output logic               busy,
  output logic               ex_stall,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  alu_port_mux #(
    .WIDTH(WIDTH)
  ) u_port_mux (
    .owned      (state == S_ITER),
    .own_sel    (SEL_ADD),
    .own_inp1   (hi),
    .own_addend (mcand),
    .own_gate   (lo[0]),
    .ex_inp1    (ex_inp1),
    .ex_inp2    (ex_inp2),
    .ex_sel     (ex_sel),
    .alu_inp1   (alu_inp1),
    .alu_inp2   (alu_inp2),
    .alu_sel    (alu_sel)
  );

  // The ALU has no carry-out, so rebuild it from the operand and sum MSBs.
  assign carry = (alu_inp1[WIDTH-1] & alu_inp2[WIDTH-1])
               | ((alu_inp1[WIDTH-1] | alu_inp2[WIDTH-1]) & ~alu_outp[WIDTH-1]);

  assign next_hi  = {carry, alu_outp[WIDTH-1:1]};
  assign next_lo  = {alu_outp[0], lo[WIDTH-1:1]};
  assign ex_stall = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= mul_a;
            lo    <= mul_b;
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          hi  <= next_hi;
          lo  <= next_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            product <= {next_hi, next_lo};
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized directed bench against a product/timeline model
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mul_a, mul_b, ex_inp1, ex_inp2, alu_outp;
  logic [31:0] alu_inp1, alu_inp2;
  logic [2:0]  ex_sel, alu_sel;
  logic        busy, ex_stall, done;
  logic [63:0] product;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_product;

  always #5 clk = ~clk;

  alu_mul_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .ex_inp1  (ex_inp1),
    .ex_inp2  (ex_inp2),
    .ex_sel   (ex_sel),
    .alu_outp (alu_outp),
    .alu_inp1 (alu_inp1),
    .alu_inp2 (alu_inp2),
    .alu_sel  (alu_sel),
    .busy     (busy),
    .ex_stall (ex_stall),
    .done     (done),
    .product  (product)
  );

  // Stand-in for the shared ALU the sequencer drives.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_outp = {31'd0, alu_inp1 < alu_inp2};
      3'b001:  alu_outp = alu_inp1 & alu_inp2;
      3'b010:  alu_outp = alu_inp1 ^ alu_inp2;
      3'b011:  alu_outp = alu_inp1 | alu_inp2;
      3'b100:  alu_outp = alu_inp1 - 32'd1;
      3'b101:  alu_outp = alu_inp1 + alu_inp2;
      3'b110:  alu_outp = alu_inp1 - alu_inp2;
      default: alu_outp = alu_inp1 + 32'd1;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_passthrough(input string tag);
    check({tag, "_sel"},  {61'd0, alu_sel}, {61'd0, ex_sel});
    check({tag, "_inp1"}, {32'd0, alu_inp1}, {32'd0, ex_inp1});
    check({tag, "_inp2"}, {32'd0, alu_inp2}, {32'd0, ex_inp2});
  endtask

  // mode 0: plain op; 1: extra starts at cycle 10 and in DONE; 2: reset at cycle 10
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [63:0] exp_p;
    exp_p   = {32'd0, a} * {32'd0, b};
    mul_a   = a;
    mul_b   = b;
    start   = 1'b1;
    ex_sel  = 3'b110;
    ex_inp1 = $urandom;
    ex_inp2 = $urandom;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      start = 1'b0;
      mul_a = $urandom;
      mul_b = $urandom;
      check("busy", {63'd0, busy}, 64'd1);
      check("ex_stall", {63'd0, ex_stall}, 64'd1);
      check("done", {63'd0, done}, {63'd0, k == 33});
      if (k <= 32) check("iter_sel", {61'd0, alu_sel}, 64'd5);
      else         check_passthrough("done_pt");
      check("product", product, (k == 33) ? exp_p : last_product);
      if (mode == 2 && k == 10) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_stall", {63'd0, ex_stall}, 64'd0);
        check_passthrough("rst_pt");
        last_product = 64'd0;
        return;
      end
      if (mode == 1 && (k == 10 || k == 33)) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_done", {63'd0, done}, 64'd0);
    check("idle_product", product, exp_p);
    check_passthrough("idle_pt");
    last_product = exp_p;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mul_a   = 32'd0;
    mul_b   = 32'd0;
    ex_inp1 = 32'd0;
    ex_inp2 = 32'd0;
    ex_sel  = 3'b000;
    last_product = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_stall", {63'd0, ex_stall}, 64'd0);

    ex_sel  = 3'b110;
    ex_inp1 = 32'd10;
    ex_inp2 = 32'd3;
    #1;
    check("idle_sel", {61'd0, alu_sel}, 64'd6);
    check("idle_inp1", {32'd0, alu_inp1}, 64'd10);
    check("idle_inp2", {32'd0, alu_inp2}, 64'd3);
    check("idle_stall", {63'd0, ex_stall}, 64'd0);
    @(negedge clk);

    run_op(32'd3, 32'd5, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(32'h8000_0000, 32'd2, 0);
    run_op(32'd0, 32'h1234, 0);
    run_op($urandom, $urandom, 1);
    run_op($urandom, $urandom, 2);
    run_op(32'd7, 32'd6, 0);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, (i == 2) ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
